// File: rtl/mdl_sdcmd.sv
// Card-side model of the SD CMD line: receives host commands,
// serialises R1/R3/R6/R7/R2 responses and flags open-drain collisions.
module mdl_sdcmd (
  input  logic         sd_clk,
  input  logic         rst_n,
  inout  wire          sd_cmd,
  output logic         sd_ds,
  output logic         o_cmd_valid,
  output logic [5:0]   o_cmd,
  output logic [31:0]  o_arg,
  output logic         o_crc_err,
  input  logic         i_valid,
  input  logic         i_type,
  output logic         o_busy,
  input  logic [5:0]   i_reply,
  input  logic [119:0] i_arg,
  input  logic         i_use_crc,
  input  logic         i_drive,
  output logic         o_collision
);

  localparam logic RX_IDLE = 1'b0;
  localparam logic RX_DATA = 1'b1;

  function automatic logic [6:0] crc7_nx(input logic [6:0] c,
                                         input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  logic line_s;
  assign line_s = (sd_cmd !== 1'b0);

  logic         s_q, s_d;
  logic         rx_st_q, rx_st_d;
  logic [5:0]   rx_cnt_q, rx_cnt_d;
  logic [46:0]  rx_sr_q, rx_sr_d;
  logic [6:0]   rx_crc_q, rx_crc_d;
  logic         cmd_valid_q, cmd_valid_d;
  logic [5:0]   cmd_q, cmd_d;
  logic [31:0]  arg_q, arg_d;
  logic         crc_err_q, crc_err_d;

  logic         busy_q, busy_d;
  logic [7:0]   tx_cnt_q, tx_cnt_d;
  logic [135:0] tx_sr_q, tx_sr_d;
  logic [6:0]   tx_crc_q, tx_crc_d;
  logic         tx_type_q, tx_type_d;
  logic         tx_use_crc_q, tx_use_crc_d;
  logic         tx_drive_q, tx_drive_d;
  logic         en_q, en_d;
  logic         bit_q, bit_d;
  logic         coll_q, coll_d;
  logic         oe_q, oe_d;
  logic         od_q, od_d;

  logic         rx_act;
  logic         accept;
  logic [7:0]   tx_len;
  logic [7:0]   tx_cs;
  logic [7:0]   tx_lo;
  logic [7:0]   tx_j;
  logic         tx_b;

  always_comb begin
    s_d         = line_s;
    rx_st_d     = rx_st_q;
    rx_cnt_d    = rx_cnt_q;
    rx_sr_d     = rx_sr_q;
    rx_crc_d    = rx_crc_q;
    cmd_valid_d = 1'b0;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    crc_err_d   = crc_err_q;
    unique case (1'b1)
      (rx_st_q == RX_IDLE): begin
        if (!busy_q && !s_q) begin
          rx_st_d  = RX_DATA;
          rx_cnt_d = 6'd1;
          rx_crc_d = 7'd0;
        end
      end
      default: begin
        rx_sr_d  = {rx_sr_q[45:0], s_q};
        rx_cnt_d = rx_cnt_q + 6'd1;
        if (rx_cnt_q < 6'd40) begin
          rx_crc_d = crc7_nx(rx_crc_q, s_q);
        end
        if (rx_cnt_q == 6'd47) begin
          rx_st_d = RX_IDLE;
          if (rx_sr_d[46]) begin
            cmd_valid_d = 1'b1;
            cmd_d       = rx_sr_d[45:40];
            arg_d       = rx_sr_d[39:8];
            crc_err_d   = (rx_sr_d[7:1] != rx_crc_q) || !rx_sr_d[0];
          end
        end
      end
    endcase
  end

  // A frame in flight or a start bit just seen keeps Ncr from elapsing.
  assign rx_act = (rx_st_q != RX_IDLE) || !s_q;
  assign accept = i_valid && !busy_q && !rx_act;
  assign tx_len = tx_type_q ? 8'd136 : 8'd48;
  assign tx_cs  = tx_len - 8'd8;
  assign tx_lo  = tx_type_q ? 8'd8 : 8'd0;

  always_comb begin
    busy_d       = busy_q;
    tx_cnt_d     = tx_cnt_q;
    tx_sr_d      = tx_sr_q;
    tx_crc_d     = tx_crc_q;
    tx_type_d    = tx_type_q;
    tx_use_crc_d = tx_use_crc_q;
    tx_drive_d   = tx_drive_q;
    en_d         = en_q;
    bit_d        = bit_q;
    coll_d       = coll_q;
    tx_j         = tx_cnt_q - 8'd1;
    tx_b         = 1'b1;
    if (accept) begin
      busy_d       = 1'b1;
      tx_cnt_d     = 8'd0;
      tx_crc_d     = 7'd0;
      tx_type_d    = i_type;
      tx_use_crc_d = i_use_crc;
      tx_drive_d   = i_drive;
      en_d         = 1'b0;
      bit_d        = 1'b1;
      coll_d       = 1'b0;
      tx_sr_d      = i_type ? {2'b00, 6'h3F, i_arg, 8'hFF}
                            : {2'b00, i_reply, i_arg[31:0], {96{1'b1}}};
    end else if (busy_q) begin
      tx_cnt_d = tx_cnt_q + 8'd1;
      if (tx_cnt_q >= 8'd1 && tx_cnt_q <= tx_len) begin
        if (tx_j < tx_cs) begin
          tx_b = tx_sr_q[135];
          if (tx_j >= tx_lo) begin
            tx_crc_d = crc7_nx(tx_crc_q, tx_b);
          end
        end else if (tx_j < tx_len - 8'd1) begin
          tx_b     = tx_use_crc_q ? tx_crc_q[6] : 1'b1;
          tx_crc_d = {tx_crc_q[5:0], 1'b0};
        end
        tx_sr_d = {tx_sr_q[134:0], 1'b0};
        en_d    = 1'b1;
        bit_d   = tx_b;
      end else begin
        en_d = 1'b0;
      end
      if (tx_cnt_q == tx_len + 8'd2) begin
        busy_d = 1'b0;
      end
      if (!tx_drive_q && en_q && bit_q && !coll_q && !line_s) begin
        coll_d = 1'b1;
      end
    end
  end

  // Output stage updates on the falling edge so the host samples mid-bit.
  assign oe_d = en_q && !coll_q && (tx_drive_q || !bit_q);
  assign od_d = bit_q;

  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q          <= 1'b1;
      rx_st_q      <= RX_IDLE;
      rx_cnt_q     <= 6'd0;
      rx_sr_q      <= '0;
      rx_crc_q     <= 7'd0;
      cmd_valid_q  <= 1'b0;
      cmd_q        <= 6'd0;
      arg_q        <= 32'd0;
      crc_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      tx_cnt_q     <= 8'd0;
      tx_sr_q      <= '0;
      tx_crc_q     <= 7'd0;
      tx_type_q    <= 1'b0;
      tx_use_crc_q <= 1'b0;
      tx_drive_q   <= 1'b0;
      en_q         <= 1'b0;
      bit_q        <= 1'b1;
      coll_q       <= 1'b0;
    end else begin
      s_q          <= s_d;
      rx_st_q      <= rx_st_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_sr_q      <= rx_sr_d;
      rx_crc_q     <= rx_crc_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_q        <= cmd_d;
      arg_q        <= arg_d;
      crc_err_q    <= crc_err_d;
      busy_q       <= busy_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_sr_q      <= tx_sr_d;
      tx_crc_q     <= tx_crc_d;
      tx_type_q    <= tx_type_d;
      tx_use_crc_q <= tx_use_crc_d;
      tx_drive_q   <= tx_drive_d;
      en_q         <= en_d;
      bit_q        <= bit_d;
      coll_q       <= coll_d;
    end
  end

  always_ff @(negedge sd_clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_q <= 1'b0;
      od_q <= 1'b1;
    end else begin
      oe_q <= oe_d;
      od_q <= od_d;
    end
  end

  assign sd_cmd      = oe_q ? od_q : 1'bz;
  assign sd_ds       = oe_q && tx_drive_q && sd_clk;
  assign o_cmd_valid = cmd_valid_q;
  assign o_cmd       = cmd_q;
  assign o_arg       = arg_q;
  assign o_crc_err   = crc_err_q;
  assign o_busy      = busy_q;
  assign o_collision = coll_q;

endmodule

// File: tb/tb_mdl_sdcmd.sv
// Directed bench for mdl_sdcmd: host command frames,
// response framing, Ncr hold-off, collision and async reset.
module tb_mdl_sdcmd;

  logic         sd_clk = 1'b0;
  logic         rst_n  = 1'b0;
  wire          sd_cmd;
  logic         h_oe   = 1'b0;
  logic         h_bit  = 1'b1;
  logic         sd_ds;
  logic         o_cmd_valid;
  logic [5:0]   o_cmd;
  logic [31:0]  o_arg;
  logic         o_crc_err;
  logic         i_valid   = 1'b0;
  logic         i_type    = 1'b0;
  logic         o_busy;
  logic [5:0]   i_reply   = 6'd0;
  logic [119:0] i_arg     = '0;
  logic         i_use_crc = 1'b0;
  logic         i_drive   = 1'b0;
  logic         o_collision;

  int n_run  = 0;
  int n_fail = 0;

  assign sd_cmd = h_oe ? h_bit : 1'bz;
  pullup (sd_cmd);

  logic lb;
  assign lb = (sd_cmd !== 1'b0);

  always #5 sd_clk = ~sd_clk;

  mdl_sdcmd dut (
    .sd_clk      (sd_clk),
    .rst_n       (rst_n),
    .sd_cmd      (sd_cmd),
    .sd_ds       (sd_ds),
    .o_cmd_valid (o_cmd_valid),
    .o_cmd       (o_cmd),
    .o_arg       (o_arg),
    .o_crc_err   (o_crc_err),
    .i_valid     (i_valid),
    .i_type      (i_type),
    .o_busy      (o_busy),
    .i_reply     (i_reply),
    .i_arg       (i_arg),
    .i_use_crc   (i_use_crc),
    .i_drive     (i_drive),
    .o_collision (o_collision)
  );

  task automatic chk(input string tag, input logic [135:0] got,
                     input logic [135:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [119:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 119; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  task automatic send_cmd(input logic [47:0] f);
    for (int i = 0; i < 48; i++) begin
      @(negedge sd_clk);
      h_oe  = 1'b1;
      h_bit = f[47-i];
    end
  endtask

  task automatic host_release();
    @(negedge sd_clk);
    h_oe  = 1'b0;
    h_bit = 1'b1;
  endtask

  task automatic wait_cmd(output bit got);
    got = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge sd_clk);
      #1;
      if (o_cmd_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sd_clk);
  endtask

  task automatic req(input logic t, input logic [5:0] rep,
                     input logic [119:0] a, input logic uc,
                     input logic dr);
    @(negedge sd_clk);
    i_type    = t;
    i_reply   = rep;
    i_arg     = a;
    i_use_crc = uc;
    i_drive   = dr;
    i_valid   = 1'b1;
  endtask

  task automatic scramble();
    i_valid   = 1'b0;
    i_reply   = ~i_reply;
    i_arg     = ~i_arg;
    i_use_crc = ~i_use_crc;
    i_drive   = ~i_drive;
    i_type    = ~i_type;
  endtask

  task automatic wait_acc(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge sd_clk);
      #1;
      if (o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk(tag, 136'd0, 136'd1);
    scramble();
  endtask

  task automatic capture(input string tag, input int len,
                         input int fj, output logic [135:0] fr,
                         output logic ds3);
    fr  = '0;
    ds3 = 1'b0;
    for (int k = 1; k <= len + 3; k++) begin
      @(posedge sd_clk);
      #1;
      if (k == 2) chk({tag, "_pre_rel"}, 136'(lb), 136'd1);
      if (k == 3) ds3 = sd_ds;
      if (k >= 3 && k <= len + 2) fr = {fr[134:0], lb};
      if (fj >= 0 && k == fj + 3) begin
        h_oe  = 1'b0;
        h_bit = 1'b1;
      end
      if (fj >= 0 && k == fj + 2) begin
        h_oe  = 1'b1;
        h_bit = 1'b0;
      end
      if (k == len + 2) chk({tag, "_busy_end"}, 136'(o_busy), 136'd1);
      if (k == len + 3) begin
        chk({tag, "_busy_off"}, 136'(o_busy), 136'd0);
        chk({tag, "_post_rel"}, 136'(lb), 136'd1);
      end
    end
  endtask

  logic [135:0] fr;
  logic [119:0] pat;
  logic         ds3;
  bit           got;

  initial begin
    #2;
    chk("rst_busy", 136'(o_busy), 136'd0);
    chk("rst_valid", 136'(o_cmd_valid), 136'd0);
    chk("rst_cmd", 136'(o_cmd), 136'd0);
    chk("rst_arg", 136'(o_arg), 136'd0);
    chk("rst_coll", 136'(o_collision), 136'd0);
    chk("rst_line", 136'(lb), 136'd1);
    #20;
    @(negedge sd_clk);
    rst_n = 1'b1;
    idle(3);

    send_cmd(48'h40_00000000_95);
    host_release();
    wait_cmd(got);
    chk("cmd0_pulse", 136'(got), 136'd1);
    chk("cmd0_idx", 136'(o_cmd), 136'd0);
    chk("cmd0_arg", 136'(o_arg), 136'd0);
    chk("cmd0_err", 136'(o_crc_err), 136'd0);
    @(posedge sd_clk);
    #1;
    chk("cmd0_one_cycle", 136'(o_cmd_valid), 136'd0);
    idle(3);

    send_cmd(48'h48_000001AA_87);
    host_release();
    wait_cmd(got);
    chk("cmd8_pulse", 136'(got), 136'd1);
    chk("cmd8_idx", 136'(o_cmd), 136'd8);
    chk("cmd8_arg", 136'(o_arg), 136'h1AA);
    chk("cmd8_err", 136'(o_crc_err), 136'd0);
    idle(3);

    send_cmd(48'h48_000001AA_89);
    host_release();
    wait_cmd(got);
    chk("cmd8bad_pulse", 136'(got), 136'd1);
    chk("cmd8bad_err", 136'(o_crc_err), 136'd1);
    idle(3);

    send_cmd(48'h40_00000000_94);
    host_release();
    wait_cmd(got);
    chk("endbit_pulse", 136'(got), 136'd1);
    chk("endbit_err", 136'(o_crc_err), 136'd1);
    chk("endbit_idx", 136'(o_cmd), 136'd0);
    idle(3);

    send_cmd(48'h08_000001AA_87);
    host_release();
    wait_cmd(got);
    chk("discard_nopulse", 136'(got), 136'd0);
    chk("discard_idx", 136'(o_cmd), 136'd0);
    idle(3);

    // Ncr hold-off: request raised together with the end bit.
    send_cmd(48'h48_000001AA_87);
    i_type    = 1'b0;
    i_reply   = 6'd17;
    i_arg     = 120'h900;
    i_use_crc = 1'b1;
    i_drive   = 1'b1;
    i_valid   = 1'b1;
    @(posedge sd_clk);
    #1;
    chk("ncr_p0_busy", 136'(o_busy), 136'd0);
    @(negedge sd_clk);
    h_oe  = 1'b0;
    h_bit = 1'b1;
    @(posedge sd_clk);
    #1;
    chk("ncr_p1_busy", 136'(o_busy), 136'd0);
    chk("ncr_p1_valid", 136'(o_cmd_valid), 136'd1);
    chk("ncr_p1_idx", 136'(o_cmd), 136'd8);
    @(posedge sd_clk);
    #1;
    chk("ncr_p2_busy", 136'(o_busy), 136'd1);
    scramble();
    capture("r1", 48, -1, fr, ds3);
    chk("r1_frame", fr, 136'h11_00000900_67);
    chk("r1_ds", 136'(ds3), 136'd1);
    chk("r1_ds_off", 136'(sd_ds), 136'd0);
    idle(2);

    req(1'b0, 6'h3F, 120'h80FF8000, 1'b0, 1'b1);
    wait_acc("r3_acc");
    capture("r3", 48, -1, fr, ds3);
    chk("r3_frame", fr, 136'h3F_80FF8000_FF);
    idle(2);

    req(1'b1, 6'h00, 120'd0, 1'b1, 1'b1);
    wait_acc("r2z_acc");
    capture("r2z", 136, -1, fr, ds3);
    chk("r2z_frame", fr, {8'h3F, 120'd0, 8'h01});
    idle(2);

    pat = 120'h0123456789ABCDEF_FEDCBA98765432;
    req(1'b1, 6'h00, pat, 1'b1, 1'b0);
    wait_acc("r2p_acc");
    capture("r2p", 136, -1, fr, ds3);
    chk("r2p_frame", fr, {8'h3F, pat, crc7(pat), 1'b1});
    chk("r2p_ds", 136'(ds3), 136'd0);
    chk("r2p_nocoll", 136'(o_collision), 136'd0);
    idle(2);

    req(1'b1, 6'h00, {1'b1, 119'd0}, 1'b1, 1'b0);
    wait_acc("coll_acc");
    capture("coll", 136, 8, fr, ds3);
    chk("coll_frame", fr, {8'h3F, 1'b0, {127{1'b1}}});
    chk("coll_flag", 136'(o_collision), 136'd1);
    idle(2);
    chk("coll_sticky", 136'(o_collision), 136'd1);

    req(1'b0, 6'd17, 120'h900, 1'b1, 1'b1);
    wait_acc("rst_acc");
    chk("coll_cleared", 136'(o_collision), 136'd0);
    @(posedge sd_clk);
    @(posedge sd_clk);
    @(negedge sd_clk);
    #1;
    chk("mid_start_low", 136'(lb), 136'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_line", 136'(lb), 136'd1);
    chk("mid_rst_busy", 136'(o_busy), 136'd0);
    chk("mid_rst_valid", 136'(o_cmd_valid), 136'd0);
    chk("mid_rst_idx", 136'(o_cmd), 136'd0);
    chk("mid_rst_arg", 136'(o_arg), 136'd0);
    chk("mid_rst_ds", 136'(sd_ds), 136'd0);
    #20;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
